// File: rtl/eth_pkg.sv
// Shared Ethernet receive definitions: capture FSM states,
// packing geometry and preamble/SFD byte values.
package eth_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    CAPTURE,
    FLUSH,
    DONE,
    DROP
  } cap_state_e;

  localparam int DIBITS_PER_WORD = 16;
  localparam logic [7:0] ETH_PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] ETH_SFD_BYTE = 8'hD5;

  function automatic logic [15:0] sat_add(
    input logic [15:0] v,
    input logic [1:0]  n
  );
    logic [16:0] s;
    s = {1'b0, v} + {15'd0, n};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic is_preamble(input logic [7:0] b);
    return b == ETH_PREAMBLE_BYTE;
  endfunction

  function automatic logic is_sfd(input logic [7:0] b);
    return b == ETH_SFD_BYTE;
  endfunction

endpackage

// File: rtl/rmii_dibit_packer.sv
// Packs RMII dibits MSB-first into 32-bit words, dibit 0 in
// bits [31:30]; unfilled positions read back as zero.
module rmii_dibit_packer
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        shift,
  input  logic [1:0]  dibit,
  output logic        word_valid,
  output logic [31:0] word_out,
  output logic        partial
);

  localparam logic [3:0] LAST = 4'(DIBITS_PER_WORD - 1);

  logic [3:0]  cnt;
  logic [31:0] sr;
  logic [3:0]  cur_cnt;
  logic [31:0] cur_sr;
  logic [31:0] ins;

  // Current word view, with the incoming dibit merged in
  always_comb begin
    cur_cnt    = start ? 4'd0 : cnt;
    cur_sr     = start ? 32'd0 : sr;
    ins        = {dibit, 30'd0} >> {cur_cnt, 1'b0};
    word_out   = shift ? (cur_sr | ins) : cur_sr;
    word_valid = shift && (cur_cnt == LAST);
  end

  assign partial = (cnt != 4'd0);

  // Shift register and dibit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
      sr  <= 32'd0;
    end else if (shift) begin
      if (word_valid) begin
        cnt <= 4'd0;
        sr  <= 32'd0;
      end else begin
        cnt <= cur_cnt + 4'd1;
        sr  <= word_out;
      end
    end else if (start) begin
      cnt <= 4'd0;
      sr  <= 32'd0;
    end
  end

endmodule

// File: rtl/rmii_rx_capture.sv
// RMII receive capture into frame RAM with runt/overflow filtering.
// Optional RMII_RX_SYNC_EN adds 2-flop input registers on crs_dv/rxd.
module rmii_rx_capture
  import eth_pkg::*;
#(
  parameter int ADDR_W    = 9,
  parameter int MIN_WORDS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              crs_dv,
  input  logic [1:0]        rxd,
  input  logic              hold,
  output logic              wr_ena,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              newpacket,
  output logic [ADDR_W-1:0] last_word,
  output logic              overflow,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       drop_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] MIN_CNT = (ADDR_W + 1)'(MIN_WORDS);

  logic       crs;
  logic [1:0] dibit;

`ifdef RMII_RX_SYNC_EN
  logic [1:0] crs_q;
  logic [3:0] rxd_q;

  // Input synchronisers, unreset so a live frame stays visible
  always_ff @(posedge clk) begin
    crs_q <= {crs_q[0], crs_dv};
    rxd_q <= {rxd_q[1:0], rxd};
  end

  assign crs   = crs_q[1];
  assign dibit = rxd_q[3:2];
`else
  assign crs   = crs_dv;
  assign dibit = rxd;
`endif

  cap_state_e state, nxt;

  logic [ADDR_W:0] wcount;
  logic            full;
  logic            start;
  logic            shift;
  logic            word_valid;
  logic [31:0]     word_out;
  logic            partial;
  logic            do_write;
  logic            do_ovf;
  logic            do_np;
  logic            clr_count;
  logic            fc_inc;
  logic [1:0]      drop_n;

  assign full  = (wcount == FULL_CNT);
  assign start = (state == IDLE);
  assign shift = crs && (((state == IDLE) && !hold) ||
                         (state == CAPTURE));

  rmii_dibit_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .shift      (shift),
    .dibit      (dibit),
    .word_valid (word_valid),
    .word_out   (word_out),
    .partial    (partial)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_IDLE;
    else        state <= nxt;
  end

  // Next state and per-cycle actions
  always_comb begin
    nxt       = state;
    do_write  = 1'b0;
    do_ovf    = 1'b0;
    do_np     = 1'b0;
    clr_count = 1'b0;
    fc_inc    = 1'b0;
    drop_n    = 2'd0;
    unique case (state)
      WAIT_IDLE: begin
        if (!crs) nxt = IDLE;
      end
      IDLE: begin
        if (crs) begin
          if (hold) begin
            drop_n = 2'd1;
            nxt    = DROP;
          end else begin
            clr_count = 1'b1;
            nxt       = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        if (crs) begin
          if (word_valid) begin
            if (full) begin
              do_ovf = 1'b1;
              drop_n = 2'd1;
              nxt    = DROP;
            end else begin
              do_write = 1'b1;
            end
          end
        end else begin
          nxt = partial ? FLUSH : DONE;
        end
      end
      FLUSH: begin
        if (full) begin
          do_ovf = 1'b1;
          drop_n = 2'd1;
          nxt    = DROP;
        end else begin
          do_write = 1'b1;
          nxt      = DONE;
        end
      end
      DONE: begin
        if (wcount >= MIN_CNT) begin
          do_np  = 1'b1;
          fc_inc = 1'b1;
        end else begin
          drop_n = 2'd1;
        end
        if (crs) begin
          drop_n = drop_n + 2'd1;
          nxt    = WAIT_IDLE;
        end else begin
          nxt = IDLE;
        end
      end
      DROP: begin
        if (!crs) nxt = IDLE;
      end
      default: nxt = WAIT_IDLE;
    endcase
  end

  // Write port, address counter, pulses and statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ena    <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 32'd0;
      newpacket <= 1'b0;
      last_word <= '0;
      overflow  <= 1'b0;
      frame_cnt <= 16'd0;
      drop_cnt  <= 16'd0;
      wcount    <= '0;
    end else begin
      wr_ena    <= do_write;
      overflow  <= do_ovf;
      newpacket <= do_np;
      if (clr_count) begin
        wcount <= '0;
      end else if (do_write) begin
        wr_addr <= wcount[ADDR_W-1:0];
        wr_data <= word_out;
        wcount  <= wcount + 1'b1;
      end
      if (do_np) begin
        last_word <= wcount[ADDR_W-1:0] - 1'b1;
      end
      if (fc_inc) begin
        frame_cnt <= sat_add(frame_cnt, 2'd1);
      end
      drop_cnt <= sat_add(drop_cnt, drop_n);
    end
  end

endmodule

// File: tb/tb_rmii_rx_capture.sv
// Scoreboard bench for rmii_rx_capture: a frame-level model
// queues expected writes/events, a monitor checks them.
module tb_rmii_rx_capture;

  localparam int ADDR_W    = 9;
  localparam int MIN_WORDS = 16;
  localparam int DEPTH     = 2 ** ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              crs_dv;
  logic [1:0]        rxd;
  logic              hold;
  logic              wr_ena;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              newpacket;
  logic [ADDR_W-1:0] last_word;
  logic              overflow;
  logic [15:0]       frame_cnt;
  logic [15:0]       drop_cnt;

  rmii_rx_capture #(
    .ADDR_W    (ADDR_W),
    .MIN_WORDS (MIN_WORDS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .crs_dv    (crs_dv),
    .rxd       (rxd),
    .hold      (hold),
    .wr_ena    (wr_ena),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .newpacket (newpacket),
    .last_word (last_word),
    .overflow  (overflow),
    .frame_cnt (frame_cnt),
    .drop_cnt  (drop_cnt)
  );

  always #10 clk = ~clk;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    bit ovf;
    int lw;
    int due;
  } ev_t;

  typedef struct {
    int kind;
    int fc;
    int dc;
    int lw;
  } req_t;

  wr_t  wq[$];
  ev_t  evq[$];
  req_t rq[$];

  int cyc = 0;
  int ntests = 0;
  int nfail = 0;

  int m_fc = 0;
  int m_dc = 0;
  int m_lw = 0;

  always @(posedge clk) cyc <= cyc + 1;

  wr_t  mw;
  ev_t  me;
  req_t mr;

  // Monitor: pops expectations whenever the DUT presents output
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_ena) begin
        ntests++;
        if (wq.size() == 0) begin
          nfail++;
          $display("FAIL wr_unexpected addr=%0d data=%h, required no write",
                   wr_addr, wr_data);
        end else begin
          mw = wq.pop_front();
          if (int'(wr_addr) != mw.addr || wr_data !== mw.data) begin
            nfail++;
            $display("FAIL wr addr=%0d data=%h, required addr=%0d data=%h",
                     wr_addr, wr_data, mw.addr, mw.data);
          end
        end
      end
      if (newpacket) begin
        ntests++;
        if (evq.size() == 0) begin
          nfail++;
          $display("FAIL newpacket_unexpected last_word=%0d", last_word);
        end else begin
          me = evq.pop_front();
          if (me.ovf || int'(last_word) != me.lw ||
              (me.due >= 0 && cyc != me.due)) begin
            nfail++;
            $display("FAIL newpacket last_word=%0d cyc=%0d, required ovf=%0d last_word=%0d cyc=%0d",
                     last_word, cyc, me.ovf, me.lw, me.due);
          end
        end
      end
      if (overflow) begin
        ntests++;
        if (evq.size() == 0) begin
          nfail++;
          $display("FAIL overflow_unexpected cyc=%0d", cyc);
        end else begin
          me = evq.pop_front();
          if (!me.ovf) begin
            nfail++;
            $display("FAIL overflow got overflow, required newpacket last_word=%0d",
                     me.lw);
          end
        end
      end
    end
    if (rq.size() > 0) begin
      mr = rq.pop_front();
      if (mr.kind == 1) begin
        ntests++;
        if ({wr_ena, wr_addr, wr_data, newpacket, last_word,
             overflow, frame_cnt, drop_cnt} !== '0) begin
          nfail++;
          $display("FAIL reset_outputs wr_ena=%b addr=%0d data=%h np=%b lw=%0d ovf=%b fc=%0d dc=%0d, required all 0",
                   wr_ena, wr_addr, wr_data, newpacket, last_word,
                   overflow, frame_cnt, drop_cnt);
        end
      end else begin
        ntests++;
        if (int'(frame_cnt) != mr.fc) begin
          nfail++;
          $display("FAIL frame_cnt got %0d, required %0d", frame_cnt, mr.fc);
        end
        ntests++;
        if (int'(drop_cnt) != mr.dc) begin
          nfail++;
          $display("FAIL drop_cnt got %0d, required %0d", drop_cnt, mr.dc);
        end
        ntests++;
        if (int'(last_word) != mr.lw) begin
          nfail++;
          $display("FAIL last_word got %0d, required %0d", last_word, mr.lw);
        end
        ntests++;
        if (wq.size() != 0) begin
          nfail++;
          $display("FAIL writes_missing got %0d pending, required 0", wq.size());
          wq.delete();
        end
        ntests++;
        if (evq.size() != 0) begin
          nfail++;
          $display("FAIL events_missing got %0d pending, required 0", evq.size());
          evq.delete();
        end
      end
    end
  end

  // Drive one frame and queue what the frame rules predict.
  // abort_at >= 0 pulses reset for 3 cycles before that dibit.
  task automatic send(input int len, input bit hold_on, input int abort_at);
    logic [7:0] fb[$];
    logic [1:0] dib[$];
    logic [7:0] b;
    logic [31:0] w;
    int nd, nw, c0, lat, nwr, idx;
    wr_t  e;
    ev_t  v;
    req_t r;
    for (int i = 0; i < len; i++) begin
      if (i < 7)       b = 8'h55;
      else if (i == 7) b = 8'hD5;
      else             b = 8'($urandom);
      fb.push_back(b);
      for (int j = 0; j < 4; j++) dib.push_back(b[2*j +: 2]);
    end
    nd = dib.size();
    nw = (nd + 15) / 16;
    @(negedge clk);
    c0 = cyc;
    lat = (nd % 16 != 0) ? 2 : 1;
`ifdef RMII_RX_SYNC_EN
    lat += 2;
`endif
    if (abort_at >= 0)  nwr = abort_at / 16;
    else if (hold_on)   nwr = 0;
    else                nwr = (nw > DEPTH) ? DEPTH : nw;
    for (int k = 0; k < nwr; k++) begin
      w = 32'd0;
      for (int i = 0; i < 16; i++) begin
        idx = 16 * k + i;
        if (idx < nd) w = w | (32'(dib[idx]) << (30 - 2 * i));
      end
      e.addr = k;
      e.data = w;
      wq.push_back(e);
    end
    if (abort_at < 0) begin
      if (hold_on) begin
        m_dc++;
      end else if (nw > DEPTH) begin
        v.ovf = 1'b1; v.lw = 0; v.due = -1;
        evq.push_back(v);
        m_dc++;
      end else if (nw < MIN_WORDS) begin
        m_dc++;
      end else begin
        v.ovf = 1'b0; v.lw = nw - 1; v.due = c0 + nd + 1 + lat;
        evq.push_back(v);
        m_fc++;
        m_lw = nw - 1;
      end
    end
    for (int i = 0; i < nd; i++) begin
      if (i == abort_at) begin
        rst_n = 1'b0;
        m_fc = 0; m_dc = 0; m_lw = 0;
        @(posedge clk);
        r.kind = 1; r.fc = 0; r.dc = 0; r.lw = 0;
        rq.push_back(r);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
      end
      crs_dv = 1'b1;
      rxd    = dib[i];
      hold   = hold_on && (i < 40);
      @(negedge clk);
    end
    crs_dv = 1'b0;
    rxd    = 2'b00;
    hold   = 1'b0;
    repeat (12) @(negedge clk);
    r.kind = 0; r.fc = m_fc; r.dc = m_dc; r.lw = m_lw;
    rq.push_back(r);
  endtask

  initial begin
    req_t r0;
    rst_n  = 1'b0;
    crs_dv = 1'b0;
    rxd    = 2'b00;
    hold   = 1'b0;
    r0.kind = 1; r0.fc = 0; r0.dc = 0; r0.lw = 0;
    rq.push_back(r0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    send(64, 1'b0, -1);
    send(66, 1'b0, -1);
    send(20, 1'b0, -1);
    send(2100, 1'b0, -1);
    send(64, 1'b0, -1);
    send(100, 1'b1, -1);
    send(70, 1'b0, -1);
    repeat (15) send($urandom_range(8, 160), 1'b0, -1);
    send(80, 1'b0, 104);
    send(64, 1'b0, -1);
    send(9, 1'b0, -1);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
